mcu_sample_dac: RTL

//  Downstream of the sound MCU's P1 sample port. Takes the 8-bit unsigned DAC byte on ce_8m.

---
 rtl/mcu_audio_pkg.sv | 25 ++
 rtl/mcu_dac_dcblock.sv | 54 +++++
 rtl/mcu_sample_dac.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mcu_audio_pkg.sv
// Shared sample types and helpers for the sound-MCU audio path.
package mcu_audio_pkg;

    typedef logic signed [7:0]  s8_t;
    typedef logic signed [15:0] s16_t;

    localparam logic [7:0] S8_SILENCE = 8'h80;

    // Clamp a wide signed intermediate into the 16-bit sample range.
    function automatic s16_t sat16(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return 16'sh7fff;
        end
        if (x < -32'sd32768) begin
            return 16'sh8000;
        end
        return 16'(x);
    endfunction

    // Offset-binary DAC byte to two's complement.
    function automatic s8_t to_s8(input logic [7:0] b);
        return {~b[7], b[6:0]};
    endfunction

endpackage

// File: rtl/mcu_dac_dcblock.sv
// Strobe-rate output stage: DC blocker when MCU_DAC_DCBLOCK_EN is defined,
// otherwise a plain output register.
module mcu_dac_dcblock
    import mcu_audio_pkg::*;
#(
    parameter int unsigned DC_SHIFT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  s16_t x,
    output s16_t y,
    output logic valid
);

    if (DC_SHIFT < 1 || DC_SHIFT > 15) begin : g_shift_range
        $error("DC_SHIFT must be 1..15");
    end

`ifdef MCU_DAC_DCBLOCK_EN
    s16_t              x_prev;
    logic signed [31:0] y_next_c;

    // One-pole high-pass: y = x - x_prev + y_prev - y_prev/2^DC_SHIFT.
    assign y_next_c = 32'(x) - 32'(x_prev) + 32'(y) - (32'(y) >>> DC_SHIFT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_prev <= '0;
            y      <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                x_prev <= x;
                y      <= sat16(y_next_c);
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                y <= x;
            end
        end
    end
`endif

endmodule

// File: rtl/mcu_sample_dac.sv
// MCU P1 sample port to mixer: signed conversion, box average, idle ramp, volume/mute.
// Optional DC blocker on the output when MCU_DAC_DCBLOCK_EN is defined.
module mcu_sample_dac
    import mcu_audio_pkg::*;
#(
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned IDLE_CYCLES = 65536,
    parameter int unsigned RAMP_DIV    = 64,
    parameter int unsigned DC_SHIFT    = 8
) (
    input  logic       CLK_32M,
    input  logic       reset_n,
    input  logic       ce_8m,
    input  logic [7:0] sample_in,
    input  logic       sample_strobe,
    input  logic [7:0] volume,
    input  logic       mute,
    output s16_t       sample_out,
    output logic       sample_valid,
    output logic       active
);

    localparam int unsigned ACC_W  = 8 + AVG_LOG2;
    localparam int unsigned AVG_N  = 1 << AVG_LOG2;
    localparam int unsigned CNT_W  = AVG_LOG2 + 1;
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned RAMP_W = $clog2(RAMP_DIV + 1);

    if (AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_avg_range
        $error("AVG_LOG2 must be 1..4");
    end
    if (IDLE_CYCLES < 1 || RAMP_DIV < 1) begin : g_idle_range
        $error("IDLE_CYCLES and RAMP_DIV must be at least 1");
    end

    logic [7:0]              in_q;
    s8_t                     held;
    logic [IDLE_W-1:0]       idle_cnt;
    logic [RAMP_W-1:0]       ramp_cnt;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        add_cnt;
    s8_t                     avg8;
    logic                    change_c;
    s16_t                    prod_c;
    s16_t                    scaled_c;
    logic                    blk_en_c;
    s16_t                    blk_x_c;

    assign change_c = ce_8m && (sample_in != in_q);

    // Input capture, activity tracking and idle ramp of the held value.
    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            in_q     <= S8_SILENCE;
            held     <= '0;
            idle_cnt <= '0;
            ramp_cnt <= '0;
            active   <= 1'b0;
        end else if (ce_8m) begin
            in_q <= sample_in;
            if (change_c) begin
                held     <= to_s8(sample_in);
                idle_cnt <= '0;
                ramp_cnt <= '0;
                active   <= 1'b1;
            end else begin
                if (idle_cnt != IDLE_W'(IDLE_CYCLES)) begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                    if (idle_cnt == IDLE_W'(IDLE_CYCLES - 1)) begin
                        active <= 1'b0;
                    end
                end
                if (active) begin
                    ramp_cnt <= '0;
                end else if (ramp_cnt == RAMP_W'(RAMP_DIV - 1)) begin
                    ramp_cnt <= '0;
                    if (held > 0) begin
                        held <= held - 8'sd1;
                    end else if (held < 0) begin
                        held <= held + 8'sd1;
                    end
                end else begin
                    ramp_cnt <= ramp_cnt + RAMP_W'(1);
                end
            end
        end
    end

    // Box average: a full window is published on the following tick, which also starts the next one.
    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            add_cnt <= '0;
            avg8    <= '0;
        end else if (ce_8m) begin
            if (add_cnt == CNT_W'(AVG_N)) begin
                avg8    <= 8'(acc >>> AVG_LOG2);
                acc     <= ACC_W'(held);
                add_cnt <= CNT_W'(1);
            end else begin
                acc     <= acc + ACC_W'(held);
                add_cnt <= add_cnt + CNT_W'(1);
            end
        end
    end

    // Full-range product fits 16 bits: -128*255 .. 127*255.
    assign prod_c   = 16'(avg8) * 16'($signed({1'b0, volume}));
    assign scaled_c = mute ? '0 : prod_c;

`ifdef MCU_DAC_DCBLOCK_EN
    s16_t stage_q;
    logic stage_v;

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
            stage_v <= 1'b0;
        end else begin
            stage_v <= sample_strobe;
            if (sample_strobe) begin
                stage_q <= scaled_c;
            end
        end
    end

    assign blk_en_c = stage_v;
    assign blk_x_c  = stage_q;
`else
    assign blk_en_c = sample_strobe;
    assign blk_x_c  = scaled_c;
`endif

    mcu_dac_dcblock #(
        .DC_SHIFT (DC_SHIFT)
    ) u_dcblock (
        .clk     (CLK_32M),
        .reset_n (reset_n),
        .en      (blk_en_c),
        .x       (blk_x_c),
        .y       (sample_out),
        .valid   (sample_valid)
    );

endmodule
